ripple_adder: RTL and testbench



---
 rtl/ripple_adder.sv | 42 ++++
 tb/tb_ripple_adder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ripple_adder.sv
// Unsigned WIDTH-bit ripple-carry adder with registered sum and carry-out.
// Baseline reference for the carry-lookahead members of the adder family.
module ripple_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    assign w_c[0] = 1'b0;

    // One full-adder cell per bit; the carry chain is WIDTH cells long.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic w_p;
        assign w_p      = X[i] ^ Y[i];
        assign w_s[i]   = w_p ^ w_c[i];
        assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & w_p);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s  <= '0;
            r_co <= 1'b0;
        end else begin
            r_s  <= w_s;
            r_co <= w_c[WIDTH];
        end
    end

    assign S  = r_s;
    assign Co = r_co;

endmodule

// File: tb/tb_ripple_adder.sv
// Self-checking bench for ripple_adder: directed vector table, exhaustive
// 4-bit sweep, and random 16-bit operands against an arithmetic model.
module tb_ripple_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  x4, y4, s4;
    logic        co4;
    logic [15:0] x16, y16, s16;
    logic        co16;

    int checks;
    int fails;

    ripple_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (x4),
        .Y     (y4),
        .S     (s4),
        .Co    (co4)
    );

    ripple_adder #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (x16),
        .Y     (y16),
        .S     (s16),
        .Co    (co16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[14];

    task automatic check4(input string name, input logic [4:0] act,
                          input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {Co,S}=%0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [16:0] act,
                           input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {Co,S}=%0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one operand set, clock it in, then compare both DUTs.
    task automatic step(input string name, input logic r,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp4);
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] exp16;
        ra = 16'($urandom);
        rb = 16'($urandom);
        @(negedge clk);
        rst_n = r;
        x4    = a;
        y4    = b;
        x16   = ra;
        y16   = rb;
        exp16 = r ? ({1'b0, ra} + {1'b0, rb}) : 17'd0;
        @(posedge clk);
        #1;
        check4(name, {co4, s4}, exp4);
        check16({name, "_w16"}, {co16, s16}, exp16);
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        x4     = 4'd9;
        y4     = 4'd7;
        x16    = '0;
        y16    = '0;

        vecs[0]  = '{1'b0, 4'd9,  4'd7,  4'd0,  1'b0};
        vecs[1]  = '{1'b0, 4'd9,  4'd7,  4'd0,  1'b0};
        vecs[2]  = '{1'b0, 4'd9,  4'd7,  4'd0,  1'b0};
        vecs[3]  = '{1'b1, 4'd0,  4'd0,  4'd0,  1'b0};
        vecs[4]  = '{1'b1, 4'd2,  4'd3,  4'd5,  1'b0};
        vecs[5]  = '{1'b1, 4'd15, 4'd1,  4'd0,  1'b1};
        vecs[6]  = '{1'b1, 4'd15, 4'd15, 4'd14, 1'b1};
        vecs[7]  = '{1'b1, 4'd8,  4'd8,  4'd0,  1'b1};
        vecs[8]  = '{1'b1, 4'd1,  4'd1,  4'd2,  1'b0};
        vecs[9]  = '{1'b1, 4'd7,  4'd8,  4'd15, 1'b0};
        vecs[10] = '{1'b0, 4'd6,  4'd6,  4'd0,  1'b0};
        vecs[11] = '{1'b1, 4'd10, 4'd5,  4'd15, 1'b0};
        vecs[12] = '{1'b1, 4'd12, 4'd12, 4'd8,  1'b1};
        vecs[13] = '{1'b1, 4'd15, 4'd0,  4'd15, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].x,
                 vecs[i].y, {vecs[i].co, vecs[i].s});
        end

        // Outputs must hold between edges.
        @(negedge clk);
        check4("hold", {co4, s4}, 5'd15);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            logic [4:0] e;
            p = i[7:0];
            e = {1'b0, p[7:4]} + {1'b0, p[3:0]};
            step($sformatf("exh_%0d_%0d", p[7:4], p[3:0]), 1'b1,
                 p[7:4], p[3:0], e);
        end

        for (int i = 0; i < 200; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       r;
            logic [4:0] e;
            a = 4'($urandom);
            b = 4'($urandom);
            r = ($urandom_range(0, 15) != 0);
            e = r ? ({1'b0, a} + {1'b0, b}) : 5'd0;
            step($sformatf("rnd%0d", i), r, a, b, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
